// File: rtl/fetch_seq_pkg.sv
// Shared front-end definitions: datapath width, instruction size and the fetch FSM encoding.
package fetch_seq_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam int CNT_W       = 3;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        VALID = 1'b1
    } fetch_state_t;

    // Instructions are word aligned; low address bits of any target are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_seq_if.sv
// Bundle of memory, redirect and decode-side signals around the fetch sequencer.
interface fetch_seq_if;
    import fetch_seq_pkg::*;

    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;

    modport master (
        output mem_addr, instr_valid, instr, instr_pc,
        input  mem_data, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_addr, instr_valid, instr, instr_pc,
        output mem_data, redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/fetch_seq.sv
// Fetch sequencer: walks four byte addresses per word, assembles the little-endian
// instruction from the one-cycle-latency byte memory and offers it to decode.
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic       clk,
    input  logic       rstn,
    fetch_seq_if.master bus
);

    fetch_state_t                    state_q, state_d;
    logic [XLEN-1:0]                 pc_q, pc_d;
    logic [XLEN-1:0]                 addr_q, addr_d;
    logic [XLEN-1:0]                 instr_q, instr_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [INSTR_BYTES-2:0][7:0]     buf_q, buf_d;

    logic            hs;
    logic            redir;
    logic [XLEN-1:0] redir_pc;
    logic            unused_mem_hi;

    assign hs            = (state_q == VALID) && bus.instr_ready;
    assign redir         = bus.redirect_valid;
    assign redir_pc      = align_pc(bus.redirect_pc);
    assign unused_mem_hi = ^bus.mem_data[XLEN-1:8];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= FILL;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            instr_q <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redir) begin
            state_d = FILL;
        end else begin
            unique case (state_q)
                FILL:    if (cnt_q == CNT_W'(INSTR_BYTES)) state_d = VALID;
                VALID:   if (hs) state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    // A redirect overrides everything, including a same-cycle handshake advance;
    // the handshake itself still completes because decode saw valid&&ready.
    always_comb begin
        pc_d    = pc_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        if (redir) begin
            pc_d   = redir_pc;
            addr_d = redir_pc;
            cnt_d  = '0;
        end else if (state_q == FILL) begin
            if (cnt_q <= CNT_W'(2))
                addr_d = pc_q + XLEN'(cnt_q) + XLEN'(1);
            for (int k = 0; k < INSTR_BYTES - 1; k++) begin
                if (cnt_q == CNT_W'(k + 1))
                    buf_d[k] = bus.mem_data[7:0];
            end
            if (cnt_q == CNT_W'(INSTR_BYTES))
                instr_d = {bus.mem_data[7:0], buf_q};
            else
                cnt_d = cnt_q + CNT_W'(1);
        end else if (hs) begin
            pc_d   = pc_q + XLEN'(INSTR_BYTES);
            addr_d = pc_q + XLEN'(INSTR_BYTES);
            cnt_d  = '0;
        end
    end

    assign bus.mem_addr    = addr_q;
    assign bus.instr_valid = (state_q == VALID);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = pc_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed scenarios plus a randomized run
// against a word-level reference model (base address + cycles since start).
module tb_fetch_seq;
    import fetch_seq_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    fetch_seq_if bus();

    fetch_seq #(.RESET_PC(RESET_PC)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    // Byte memory with one-cycle read latency; upper data bits are junk.
    logic [7:0] mem [256];
    always @(posedge clk) bus.mem_data <= {24'($urandom), mem[bus.mem_addr[7:0]]};

    int checks = 0;
    int fails  = 0;

    // Reference model: word at m_base, m_age cycles into its fetch (5 = presented).
    logic [31:0] m_base  = RESET_PC;
    logic [31:0] m_instr = '0;
    int          m_age   = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = mem[8'(a + 32'(k))];
        return w;
    endfunction

    function automatic logic [31:0] exp_addr();
        return m_base + 32'((m_age < 3) ? m_age : 3);
    endfunction

    task automatic tick(input logic rst_n, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic hs;
        rstn               = rst_n;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.instr_ready    = rdy;
        @(posedge clk);
        if (!rst_n) begin
            m_base = RESET_PC; m_age = 0; m_instr = '0;
        end else begin
            hs = (m_age == 5) && rdy;
            if (rv) begin
                m_base = {rpc[31:2], 2'b00}; m_age = 0;
            end else if (hs) begin
                m_base = m_base + 32'd4; m_age = 0;
            end else if (m_age < 5) begin
                m_age++;
                if (m_age == 5) m_instr = word_at(m_base);
            end
        end
        #1;
    endtask

    task automatic wait_valid(input logic rdy, output int n);
        n = 0;
        while (!bus.instr_valid && n < 20) begin
            tick(1'b1, 1'b0, 32'h0, rdy);
            n++;
        end
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
        checks++; if (bus.instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", bus.instr); end
        checks++; if (bus.mem_addr !== RESET_PC) begin fails++; $display("FAIL reset_addr: got %h want %h", bus.mem_addr, RESET_PC); end
        checks++; if (bus.instr_pc !== RESET_PC) begin fails++; $display("FAIL reset_pc: got %h want %h", bus.instr_pc, RESET_PC); end
    endtask

    task automatic test_stream();
        logic [31:0] words [3] = '{32'h0000_0293, 32'h0000_0313, 32'h00a0_0393};
        logic [31:0] trace [5] = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3};
        int n;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 32'h0, 1'b1);
            checks++;
            if (bus.mem_addr !== trace[i] || bus.instr_valid !== (i == 4)) begin
                fails++; $display("FAIL stream_fill%0d: addr %h valid %b want addr %h valid %b",
                                  i, bus.mem_addr, bus.instr_valid, trace[i], (i == 4));
            end
        end
        checks++; if (bus.instr !== words[0] || bus.instr_pc !== 32'h0) begin
            fails++; $display("FAIL stream_w0: got %h@%h want %h@0", bus.instr, bus.instr_pc, words[0]); end
        for (int k = 1; k < 3; k++) begin
            tick(1'b1, 1'b0, 32'h0, 1'b1);
            checks++; if (bus.instr_valid !== 1'b0 || bus.mem_addr !== 32'(4*k)) begin
                fails++; $display("FAIL stream_hs%0d: valid %b addr %h want 0 and %h", k, bus.instr_valid, bus.mem_addr, 32'(4*k)); end
            wait_valid(1'b1, n);
            checks++; if (n + 1 != 6) begin fails++; $display("FAIL stream_spacing%0d: got %0d want 6", k, n + 1); end
            checks++; if (bus.instr !== words[k] || bus.instr_pc !== 32'(4*k)) begin
                fails++; $display("FAIL stream_w%0d: got %h@%h want %h@%h", k, bus.instr, bus.instr_pc, words[k], 32'(4*k)); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] s_instr, s_addr;
        int n;
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        wait_valid(1'b0, n);
        checks++; if (n != 5) begin fails++; $display("FAIL bp_latency: got %0d want 5", n); end
        s_instr = bus.instr; s_addr = bus.mem_addr;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, 32'h0, 1'b0);
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== s_instr || bus.mem_addr !== s_addr) begin
                fails++; $display("FAIL bp_hold%0d: valid %b instr %h addr %h want 1 %h %h",
                                  i, bus.instr_valid, bus.instr, bus.mem_addr, s_instr, s_addr);
            end
        end
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        checks++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL bp_release: valid %b want 0", bus.instr_valid); end
        wait_valid(1'b0, n);
        checks++; if (n != 5 || bus.instr !== 32'h0000_0313 || bus.instr_pc !== 32'h4) begin
            fails++; $display("FAIL bp_next: %0d cycles %h@%h want 5 00000313@4", n, bus.instr, bus.instr_pc); end
    endtask

    task automatic test_redirect_fill();
        int n;
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        tick(1'b1, 1'b1, 32'h9, 1'b1);
        checks++; if (bus.mem_addr !== 32'h8 || bus.instr_valid !== 1'b0) begin
            fails++; $display("FAIL redir_fill_addr: addr %h valid %b want 8 0", bus.mem_addr, bus.instr_valid); end
        wait_valid(1'b1, n);
        checks++; if (n != 5 || bus.instr !== 32'h00a0_0393 || bus.instr_pc !== 32'h8) begin
            fails++; $display("FAIL redir_fill_word: %0d cycles %h@%h want 5 00a00393@8", n, bus.instr, bus.instr_pc); end
    endtask

    task automatic test_redirect_hs();
        int n;
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        wait_valid(1'b0, n);
        tick(1'b1, 1'b1, 32'h4, 1'b1);
        checks++; if (bus.instr_valid !== 1'b0 || bus.mem_addr !== 32'h4 || bus.instr_pc !== 32'h4) begin
            fails++; $display("FAIL redir_hs_edge: valid %b addr %h pc %h want 0 4 4", bus.instr_valid, bus.mem_addr, bus.instr_pc); end
        wait_valid(1'b0, n);
        checks++; if (n != 5 || bus.instr !== 32'h0000_0313 || bus.instr_pc !== 32'h4) begin
            fails++; $display("FAIL redir_hs_word: %0d cycles %h@%h want 5 00000313@4", n, bus.instr, bus.instr_pc); end
    endtask

    task automatic test_wrap();
        int n;
        tick(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        wait_valid(1'b0, n);
        checks++; if (bus.instr !== 32'hAAAA_AAAA || bus.instr_pc !== 32'hFFFF_FFFC || bus.mem_addr !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL wrap_word: %h@%h addr %h want aaaaaaaa@fffffffc addr ffffffff", bus.instr, bus.instr_pc, bus.mem_addr); end
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        checks++; if (bus.mem_addr !== 32'h0 || bus.instr_pc !== 32'h0) begin
            fails++; $display("FAIL wrap_advance: addr %h pc %h want 0 0", bus.mem_addr, bus.instr_pc); end
    endtask

    task automatic test_reset_mid();
        int n;
        tick(1'b1, 1'b1, 32'h4, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if (bus.mem_addr !== RESET_PC || bus.instr_valid !== 1'b0 || bus.instr !== 32'h0) begin
            fails++; $display("FAIL reset_mid: addr %h valid %b instr %h want %h 0 0", bus.mem_addr, bus.instr_valid, bus.instr, RESET_PC); end
        wait_valid(1'b1, n);
        checks++; if (n != 5 || bus.instr !== 32'h0000_0293 || bus.instr_pc !== RESET_PC) begin
            fails++; $display("FAIL reset_mid_restart: %0d cycles %h@%h want 5 00000293@%h", n, bus.instr, bus.instr_pc, RESET_PC); end
    endtask

    task automatic test_random();
        logic        rst_n, rv, rdy;
        logic [31:0] rpc;
        logic [31:0] r;
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 800; i++) begin
            r     = $urandom;
            rst_n = (r % 97) != 0;
            rv    = ((r >> 8) % 13) == 0;
            rdy   = ((r >> 16) % 3) != 0;
            unique case ((r >> 24) % 3)
                0:       rpc = 32'($urandom_range(0, 15));
                1:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: rpc = $urandom;
            endcase
            tick(rst_n, rv, rpc, rdy);
            checks++;
            if (bus.instr_valid !== (m_age == 5) || bus.instr !== m_instr ||
                bus.instr_pc !== m_base || bus.mem_addr !== exp_addr()) begin
                fails++;
                $display("FAIL random%0d: valid %b instr %h pc %h addr %h want %b %h %h %h",
                         i, bus.instr_valid, bus.instr, bus.instr_pc, bus.mem_addr,
                         (m_age == 5), m_instr, m_base, exp_addr());
            end
        end
    endtask

    initial begin
        logic [7:0] pre [12] = '{8'h93, 8'h02, 8'h00, 8'h00, 8'h13, 8'h03,
                                 8'h00, 8'h00, 8'h93, 8'h03, 8'ha0, 8'h00};
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 12; i++) mem[i] = pre[i];
        for (int i = 252; i < 256; i++) mem[i] = 8'hAA;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_fill();
        test_redirect_hs();
        test_wrap();
        test_reset_mid();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
